// File: rtl/program_counter_unit.sv
// -----------------------------------------------------------------------------
// program_counter_unit
//
// Fetch-stage program counter for the MIPS pipeline. Each cycle it selects the
// next fetch address with this priority: reset, exception, redirect, stall,
// return-stack pop, sequential. A small circular return-address stack (RAS)
// predicts the targets of jr $ra.
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   synchronous, active-low reset
//   Stall        in   hold the PC and the RAS
//   Exception    in   load EXC_VECTOR
//   Redirect     in   load RedirectAddr (resolved taken branch or jump)
//   RedirectAddr in   redirect target
//   Call         in   fetched instruction is jal/jalr: push PCPlusInc
//   Return       in   fetched instruction is jr $ra: pop the predicted target
//   PCResult     out  current fetch address (registered)
//   PCPlusInc    out  PCResult + INC, combinational, wraps modulo 2^WIDTH
//   Misaligned   out  registered flag, set when PCResult[1:0] != 0
//   RasCount     out  number of valid RAS entries (registered)
// -----------------------------------------------------------------------------
module program_counter_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned       INC          = 4,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           Stall,
  input  logic                           Exception,
  input  logic                           Redirect,
  input  logic [WIDTH-1:0]               RedirectAddr,
  input  logic                           Call,
  input  logic                           Return,
  output logic [WIDTH-1:0]               PCResult,
  output logic [WIDTH-1:0]               PCPlusInc,
  output logic                           Misaligned,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_t;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [WIDTH-1:0] pc_next;
  ras_op_t          ras_op;
  logic             ras_empty;

  assign PCPlusInc = PCResult + WIDTH'(INC);
  assign ras_empty = (RasCount == '0);

  // wr_ptr is the slot the next push writes; the top entry sits just below it.
  // Both wrap explicitly so RAS_DEPTH need not be a power of two. A push when
  // full simply overwrites the oldest entry, which is what a circular stack wants.
  assign top_ptr  = (wr_ptr == '0)       ? PTR_LAST : wr_ptr - PTR_ONE;
  assign next_ptr = (wr_ptr == PTR_LAST) ? '0       : wr_ptr + PTR_ONE;

  // Next-PC selection and RAS operation. A Return with an empty stack degrades
  // to plain sequential fetch (or a plain push if Call is also set), so the
  // count never underflows.
  always_comb begin
    pc_next = PCPlusInc;
    ras_op  = RAS_NONE;
    if (Exception) begin
      pc_next = EXC_VECTOR;
    end else if (Redirect) begin
      pc_next = RedirectAddr;
    end else if (Stall) begin
      pc_next = PCResult;
    end else if (Return && !ras_empty) begin
      pc_next = ras[top_ptr];
      ras_op  = Call ? RAS_SWAP : RAS_POP;
    end else if (Call) begin
      ras_op  = RAS_PUSH;
    end
  end

  // State update. Stack contents are deliberately left unreset: the count and
  // pointer reset to zero, so stale entries can never be popped.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      PCResult   <= RESET_VECTOR;
      Misaligned <= |RESET_VECTOR[1:0];
      RasCount   <= '0;
      wr_ptr     <= '0;
    end else begin
      PCResult   <= pc_next;
      Misaligned <= |pc_next[1:0];
      case (ras_op)
        RAS_PUSH: begin
          ras[wr_ptr] <= PCPlusInc;
          wr_ptr      <= next_ptr;
          if (RasCount != CNT_FULL) RasCount <= RasCount + CNT_ONE;
        end
        RAS_POP: begin
          wr_ptr   <= top_ptr;
          RasCount <= RasCount - CNT_ONE;
        end
        RAS_SWAP: begin
          ras[top_ptr] <= PCPlusInc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
